// File: rtl/spike_encoder.sv
// spike_encoder: rate-codes one pixel frame into N_STEPS spike vectors.
// Define SPIKE_ENC_DETERMINISTIC_EN for phase-accumulator coding instead of LFSRs.
module spike_encoder #(
    parameter int         N_INPUTS   = 4,
    parameter int         PIX_W      = 8,
    parameter int         N_STEPS    = 10,
    parameter int         STEP_CNT_W = 5,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic [N_INPUTS*PIX_W-1:0] pix_data,
    input  logic                      sample,
    output logic                      sample_ready,
    output logic [N_INPUTS-1:0]       spikes_out,
    output logic [STEP_CNT_W-1:0]     step_idx,
    output logic                      done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic                load;
    logic                consume;
    logic                last;
    logic [N_INPUTS-1:0] spk_load;
    logic [N_INPUTS-1:0] spk_step;

    assign pix_ready    = (state == IDLE);
    assign sample_ready = (state == RUN);
    assign load         = pix_ready & pix_valid;
    assign consume      = sample_ready & sample;
    assign last         = (step_idx == STEP_CNT_W'(N_STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (pix_valid) state_nxt = RUN;
            RUN:  if (consume && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spikes_out <= '0;
            step_idx   <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                spikes_out <= spk_load;
                step_idx   <= '0;
            end else if (consume) begin
                if (last) begin
                    spikes_out <= '0;
                    step_idx   <= '0;
                    done       <= 1'b1;
                end else begin
                    spikes_out <= spk_step;
                    step_idx   <= step_idx + STEP_CNT_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
        logic [PIX_W-1:0] pix_in;
        logic [PIX_W-1:0] pix_q;

        assign pix_in = pix_data[i*PIX_W +: PIX_W];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pix_q <= '0;
            end else if (load) begin
                pix_q <= pix_in;
            end
        end

`ifdef SPIKE_ENC_DETERMINISTIC_EN
        logic [PIX_W-1:0] acc;
        logic [PIX_W-1:0] acc_nxt;

        assign acc_nxt = acc + pix_q;
        // 0 + pix can never carry, so step 0 is always silent
        assign spk_load[i] = 1'b0;
        // carry of acc_nxt + pix_q: a + b overflows iff a > ~b
        assign spk_step[i] = (acc_nxt > ~pix_q);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc <= '0;
            end else if (load) begin
                acc <= '0;
            end else if (consume) begin
                acc <= acc_nxt;
            end
        end
`else
        localparam logic [7:0] SEED_SUM = 8'(int'(LFSR_SEED) + i);
        localparam logic [7:0] SEED     = (SEED_SUM == 8'd0) ? 8'd1 : SEED_SUM;

        logic [7:0] rnd;
        logic [7:0] rnd_nxt;

        assign rnd_nxt     = {rnd[6:0], rnd[7] ^ rnd[5] ^ rnd[4] ^ rnd[3]};
        assign spk_load[i] = (SEED <= pix_in);
        assign spk_step[i] = (rnd_nxt <= pix_q);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rnd <= SEED;
            end else if (load) begin
                rnd <= SEED;
            end else if (consume) begin
                rnd <= rnd_nxt;
            end
        end
`endif
    end

endmodule

// File: tb/tb_spike_encoder.sv
// tb_spike_encoder: scoreboard bench for spike_encoder in either coding mode.
// Expected step vectors are queued at frame load and popped as steps are consumed.
module tb_spike_encoder;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int STEPS = 10;
    localparam int CW    = 5;

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic           pix_valid = 1'b0;
    logic           sample    = 1'b0;
    logic [N*W-1:0] pix_data  = '0;
    logic           pix_ready;
    logic           sample_ready;
    logic           done;
    logic [N-1:0]   spikes_out;
    logic [CW-1:0]  step_idx;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int load_cyc = 0;
    int done_cyc = 0;

    logic [N-1:0] exp_sp[$];
    int           exp_st[$];
    logic [N-1:0] obs_sp[STEPS];
    logic [N-1:0] rec_a[STEPS];
    int           exp_cnt[N] = '{9, 5, 2, 0};

    spike_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .sample       (sample),
        .sample_ready (sample_ready),
        .spikes_out   (spikes_out),
        .step_idx     (step_idx),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    endfunction

    function automatic logic [7:0] rnd_at(input int ch, input int k);
        logic [7:0] r;
        r = 8'hA5 + 8'(ch);
        if (r == 8'd0) r = 8'd1;
        for (int j = 0; j < k; j++) r = lfsr_next(r);
        return r;
    endfunction

    function automatic logic [N-1:0] model(input logic [N*W-1:0] f, input int k);
        logic [N-1:0] v;
        int p;
        v = '0;
        for (int i = 0; i < N; i++) begin
            p = int'(f[i*W +: W]);
`ifdef SPIKE_ENC_DETERMINISTIC_EN
            v[i] = (((k + 1) * p) / 256) != ((k * p) / 256);
`else
            v[i] = (rnd_at(i, k) <= 8'(p));
`endif
        end
        return v;
    endfunction

    task automatic load_frame(input logic [N*W-1:0] f);
        check("load_pix_ready", 32'(pix_ready), 32'd1);
        pix_valid = 1'b1;
        pix_data  = f;
        load_cyc  = cyc;
        for (int k = 0; k < STEPS; k++) begin
            exp_sp.push_back(model(f, k));
            exp_st.push_back(k);
        end
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic run_steps(input logic [3:0] pat, input string tag);
        int c;
        int dones;
        c     = 0;
        dones = 0;
        while (exp_sp.size() > 0 && c < 100) begin
            check({tag, "_ready"}, 32'(sample_ready), 32'd1);
            check({tag, "_step"}, 32'(step_idx), 32'(exp_st[0]));
            check({tag, "_spikes"}, 32'(spikes_out), 32'(exp_sp[0]));
            if (pat[c % 4]) begin
                obs_sp[exp_st[0]] = spikes_out;
                void'(exp_sp.pop_front());
                void'(exp_st.pop_front());
                sample = 1'b1;
            end else begin
                sample = 1'b0;
            end
            if (done === 1'b1) dones++;
            c++;
            @(negedge clk);
        end
        sample = 1'b0;
        done_cyc = cyc;
        check({tag, "_budget"}, 32'(exp_sp.size()), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_early"}, 32'(dones), 32'd0);
        check({tag, "_idle"},
              32'({pix_ready, sample_ready, spikes_out, step_idx}),
              32'(11'b100_0000_0000));
    endtask

    initial begin
        int cnt;
        logic [STEPS-1:0] m1;
        logic [STEPS-1:0] m2;

        @(negedge clk);
        check("rst_pix_ready", 32'(pix_ready), 32'd1);
        check("rst_sample_ready", 32'(sample_ready), 32'd0);
        check("rst_spikes", 32'(spikes_out), 32'd0);
        check("rst_step", 32'(step_idx), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

`ifdef SPIKE_ENC_DETERMINISTIC_EN
        load_frame(32'h0040_80FF);
        run_steps(4'b1111, "det");
        check("det_done_latency", 32'(done_cyc - load_cyc), 32'd11);
        for (int ch = 0; ch < N; ch++) begin
            cnt = 0;
            for (int k = 0; k < STEPS; k++) cnt += int'(obs_sp[k][ch]);
            check("det_count", 32'(cnt), 32'(exp_cnt[ch]));
        end
        for (int k = 0; k < STEPS; k++) begin
            m1[k] = obs_sp[k][1];
            m2[k] = obs_sp[k][2];
        end
        check("det_ch1_steps", 32'(m1), 32'h2AA);
        check("det_ch2_steps", 32'(m2), 32'h088);
`else
        load_frame(32'h00FF_00FF);
        run_steps(4'b1111, "sat");
        check("sat_done_latency", 32'(done_cyc - load_cyc), 32'd11);
        for (int k = 0; k < STEPS; k++) begin
            check("sat_vector", 32'(obs_sp[k]), 32'h5);
        end
        m1 = '0;
        m2 = '0;
`endif
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);

        load_frame(32'h3C80_11E7);
        run_steps(4'b1111, "rep_a");
        rec_a = obs_sp;
        load_frame(32'h3C80_11E7);
        run_steps(4'b1111, "rep_b");
        for (int k = 0; k < STEPS; k++) begin
            check("rep_identical", 32'(obs_sp[k]), 32'(rec_a[k]));
        end

        load_frame(32'h9A4D_C233);
        run_steps(4'b1001, "bp");

        load_frame(32'h00FF_00FF);
        pix_valid = 1'b1;
        pix_data  = 32'h7F01_80C4;
        run_steps(4'b1111, "guard");
        load_cyc = cyc;
        for (int k = 0; k < STEPS; k++) begin
            exp_sp.push_back(model(32'h7F01_80C4, k));
            exp_st.push_back(k);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        run_steps(4'b1111, "guard_new");
        check("guard_new_latency", 32'(done_cyc - load_cyc), 32'd11);

        load_frame(32'h3C80_11E7);
        for (int k = 0; k < 4; k++) begin
            check("mid_spikes", 32'(spikes_out), 32'(exp_sp[0]));
            void'(exp_sp.pop_front());
            void'(exp_st.pop_front());
            sample = 1'b1;
            @(negedge clk);
        end
        sample = 1'b0;
        check("mid_step4", 32'(step_idx), 32'd4);
        rst = 1'b1;
        #1;
        check("mid_rst_sample_ready", 32'(sample_ready), 32'd0);
        check("mid_rst_spikes", 32'(spikes_out), 32'd0);
        check("mid_rst_step", 32'(step_idx), 32'd0);
        check("mid_rst_pix_ready", 32'(pix_ready), 32'd1);
        exp_sp.delete();
        exp_st.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_frame(32'h3C80_11E7);
        run_steps(4'b1111, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_encoder.md
# spike_encoder

Rate-coding input stage for the spiking network. It accepts one frame of pixel intensities and converts it into N_STEPS time steps of input spike vectors. Each step is served to the network core through its `sample` / `sample_ready` handshake. It sits between the frame source and the network's `in_spikes` port and is the producer side of the interface the network consumes.

## Interface
- N_INPUTS, 4, number of input channels (width of spike vector)
- PIX_W, 8, intensity width per channel; fixed at 8 when the stochastic mode is used
- N_STEPS, 10, time steps generated per frame
- STEP_CNT_W, 5, step counter width; must hold N_STEPS
- LFSR_SEED, 8'hA5, base seed; channel i seeds with LFSR_SEED + i, forced to 1 if the result is 0

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pix_valid  in  1  frame present on pix_data
- pix_ready  out  1  encoder idle, frame accepted on pix_valid & pix_ready
- pix_data  in  N_INPUTS*PIX_W  channel i at bits [i*PIX_W +: PIX_W]
- sample  in  1  network consumes current step when high with sample_ready
- sample_ready  out  1  spikes_out holds a valid step
- spikes_out  out  N_INPUTS  spike vector for the current step, to network in_spikes
- step_idx  out  STEP_CNT_W  index of the step currently on spikes_out, 0-based
- done  out  1  one-cycle pulse after the last step is consumed

## Operation
- States: IDLE, RUN.
- IDLE:
  - pix_ready=1 (combinational, state==IDLE).
  - On pix_valid, latch pix_data, reseed the generators, clear step_idx, and go to RUN.
- Entering RUN (one cycle after the load edge):
  - spikes_out holds step 0.
  - sample_ready=1.
- Consume event: sample & sample_ready.
  - If step_idx < N_STEPS-1: next edge increments step_idx, computes the next step into spikes_out, and keeps sample_ready=1 (no bubble).
  - If step_idx == N_STEPS-1: next edge clears sample_ready, spikes_out and step_idx, pulses done, and returns to IDLE.
- sample while sample_ready=0 is ignored. pix_valid outside IDLE is ignored; the latched frame is unaffected.
- Stochastic spike rule, per channel: spike = (rnd_i <= pix_i).
  - rnd_i is an 8-bit Fibonacci LFSR (taps 8,6,5,4; shift left, feedback into bit 0). The range is 1..255, never 0.
  - pix=0 never spikes; pix=255 always spikes.
  - The LFSR advances once per consume event only. The spike for step k uses the k-th state after the seed (step 0 uses the seed).
- Reset mid-frame: the frame is discarded, the state returns to IDLE, and all registers are cleared or reseeded.

## Timing
- Reset values: pix_ready=1, sample_ready=0, spikes_out=0, step_idx=0, done=0.
- Load to first valid step: 1 cycle.
- Consume to next step valid: 1 cycle; sample held high consumes one step per cycle.
- Final consume to done pulse and pix_ready=1: 1 cycle. The earliest next frame load is that same cycle.
- A frame therefore occupies at least N_STEPS+1 cycles.

## Configuration
- SPIKE_ENC_DETERMINISTIC_EN defined:
  - The LFSRs are not built; a per-channel phase accumulator is built instead.
  - The accumulator acc_i (PIX_W bits) is cleared on load.
  - Each step computes {carry, acc_i} = acc_i + pix_i and sets spike = carry.
  - Step 0 is the first addition; acc_i is committed on consume.
  - Spike count per frame = floor(N_STEPS*pix_i / 2^PIX_W).
- Undefined: the stochastic LFSR rule above.
- The handshake and timing are identical in both modes.

## Test plan
- Reset: rst asserted mid-RUN at step 4 -> next cycle sample_ready=0, spikes_out=0, step_idx=0, pix_ready=1; a fresh load restarts at step 0.
- Deterministic, sample held 1, pix={255,128,64,0} -> per-frame counts {9,5,2,0}. Channel 1 spikes on steps 1,3,5,7,9; channel 2 on steps 3,7; done pulses exactly once, 11 cycles after the load edge.
- Stochastic, pix={255,0,255,0} -> channels 0 and 2 spike all 10 steps; channels 1 and 3 never spike.
- Stochastic reproducibility: the same frame loaded twice gives bit-identical spike sequences, matching a reference LFSR model seeded at 8'hA5+i.
- Backpressure: sample toggled 1,0,0,1 with gaps -> step_idx advances only on consume; spikes_out stable during gaps; exactly 10 steps, then done.
- Load guard: pix_valid with a different frame asserted during RUN -> ignored and the current frame's outputs are unchanged. Pix_valid held through done loads the new frame on the pix_ready cycle; step 0 of the new frame appears one cycle later.
